// File: rtl/seg7_monitor.sv
// rtl/seg7_monitor.sv - seven-segment digit monitor with stability filter and sequence checking
// A pattern is accepted once it has held steady, then classified as step, skip or invalid.
module seg7_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int HEX_MODE      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       step,
  output logic       err_skip,
  output logic       err_invalid,
  output logic [7:0] step_count
);

  localparam logic [3:0] CNT_SAT   = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] DIGIT_MAX = (HEX_MODE != 0) ? 4'd15 : 4'd9;
  localparam logic       HEX_OK    = (HEX_MODE != 0);

  // Returns {decodable, value}; A-F only decode in hex mode.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'd0;
    case (pat)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {HEX_OK, 4'hA};
      7'h7C:   res = {HEX_OK, 4'hB};
      7'h39:   res = {HEX_OK, 4'hC};
      7'h5E:   res = {HEX_OK, 4'hD};
      7'h79:   res = {HEX_OK, 4'hE};
      7'h71:   res = {HEX_OK, 4'hF};
      default: res = 5'd0;
    endcase
    return res;
  endfunction

  logic [6:0] cand_q, cand_d;
  logic [6:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       committed_q, committed_d;
  logic [3:0] digit_q, digit_d;
  logic       valid_q, valid_d;
  logic       step_q, step_d;
  logic       skip_q, skip_d;
  logic       inv_q, inv_d;
  logic [7:0] count_q, count_d;

  logic [4:0] dec;
  logic [3:0] next_digit;

  assign dec        = decode(cand_q);
  assign next_digit = (digit_q == DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;

  always_comb begin
    cand_d      = cand_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    digit_d     = digit_q;
    valid_d     = valid_q;
    count_d     = count_q;
    step_d      = 1'b0;
    skip_d      = 1'b0;
    inv_d       = 1'b0;

    if (ena) begin
      if (seg_in != cand_q) begin
        cand_d      = seg_in;
        cnt_d       = 4'd0;
        committed_d = 1'b0;
      end else begin
        if (cnt_q < CNT_SAT) begin
          cnt_d = cnt_q + 4'd1;
        end
        // A run commits once; a repeat of the last accepted pattern is silent.
        if (cnt_q == CNT_SAT && !committed_q) begin
          committed_d = 1'b1;
          if (cand_q != last_q) begin
            last_d = cand_q;
            if (dec[4]) begin
              digit_d = dec[3:0];
              valid_d = 1'b1;
              if (valid_q) begin
                if (dec[3:0] == next_digit) begin
                  step_d  = 1'b1;
                  count_d = count_q + 8'd1;
                end else begin
                  skip_d = 1'b1;
                end
              end
            end else begin
              inv_d   = 1'b1;
              valid_d = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q      <= 7'd0;
      last_q      <= 7'd0;
      cnt_q       <= 4'd0;
      committed_q <= 1'b1;
      digit_q     <= 4'd0;
      valid_q     <= 1'b0;
      step_q      <= 1'b0;
      skip_q      <= 1'b0;
      inv_q       <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      cand_q      <= cand_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      digit_q     <= digit_d;
      valid_q     <= valid_d;
      step_q      <= step_d;
      skip_q      <= skip_d;
      inv_q       <= inv_d;
      count_q     <= count_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign step        = step_q;
  assign err_skip    = skip_q;
  assign err_invalid = inv_q;
  assign step_count  = count_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// tb/tb_seg7_monitor.sv - self-checking bench for seg7_monitor in hex and decimal modes
module tb_seg7_monitor;

  localparam int SC  = 4;
  localparam int BIG = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [6:0] seg_in;

  logic [3:0] digit_h, digit_d;
  logic       valid_h, valid_d;
  logic       step_h, step_d;
  logic       skip_h, skip_d;
  logic       inv_h, inv_d;
  logic [7:0] count_h, count_d;

  always #5 clk = ~clk;

  seg7_monitor #(.STABLE_CYCLES(SC), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst(rst), .ena(ena), .seg_in(seg_in),
    .digit(digit_h), .digit_valid(valid_h), .step(step_h),
    .err_skip(skip_h), .err_invalid(inv_h), .step_count(count_h)
  );

  seg7_monitor #(.STABLE_CYCLES(SC), .HEX_MODE(0)) u_dec (
    .clk(clk), .rst(rst), .ena(ena), .seg_in(seg_in),
    .digit(digit_d), .digit_valid(valid_d), .step(step_d),
    .err_skip(skip_d), .err_invalid(inv_d), .step_count(count_d)
  );

  logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = decimal instance, 1 = hex instance.
  logic [6:0] run_pat, last_pat;
  int         age;
  int         m_digit [2];
  int         m_valid [2];
  int         m_count [2];
  int         m_step  [2];
  int         m_skip  [2];
  int         m_inv   [2];

  int n_step, n_skip, n_inv, n_dstep, n_dinv;

  function automatic int lookup(input logic [6:0] p, input int mode);
    int lim;
    lim = (mode != 0) ? 16 : 10;
    for (int i = 0; i < lim; i++) begin
      if (pats[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int dv;
    int modulus;
    for (int m = 0; m < 2; m++) begin
      m_step[m] = 0;
      m_skip[m] = 0;
      m_inv[m]  = 0;
    end
    if (rst) begin
      run_pat  = 7'h00;
      last_pat = 7'h00;
      age      = BIG;
      for (int m = 0; m < 2; m++) begin
        m_digit[m] = 0;
        m_valid[m] = 0;
        m_count[m] = 0;
      end
    end else if (ena) begin
      if (seg_in != run_pat) begin
        run_pat = seg_in;
        age     = 0;
      end else if (age < BIG) begin
        age++;
      end
      if (age == SC && run_pat != last_pat) begin
        last_pat = run_pat;
        for (int m = 0; m < 2; m++) begin
          modulus = (m != 0) ? 16 : 10;
          dv = lookup(run_pat, m);
          if (dv < 0) begin
            m_inv[m]   = 1;
            m_valid[m] = 0;
          end else begin
            if (m_valid[m] != 0) begin
              if (dv == (m_digit[m] + 1) % modulus) begin
                m_step[m]  = 1;
                m_count[m] = (m_count[m] + 1) % 256;
              end else begin
                m_skip[m] = 1;
              end
            end
            m_digit[m] = dv;
            m_valid[m] = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] model_pack(input int m);
    return {16'd0, 4'(m_digit[m]), 1'(m_valid[m]), 1'(m_step[m]), 1'(m_skip[m]),
            1'(m_inv[m]), 8'(m_count[m])};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("model_hex", {16'd0, digit_h, valid_h, step_h, skip_h, inv_h, count_h}, model_pack(1));
    check("model_dec", {16'd0, digit_d, valid_d, step_d, skip_d, inv_d, count_d}, model_pack(0));
    n_step  += int'(step_h);
    n_skip  += int'(skip_h);
    n_inv   += int'(inv_h);
    n_dstep += int'(step_d);
    n_dinv  += int'(inv_d);
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) tick();
  endtask

  task automatic clr();
    n_step = 0; n_skip = 0; n_inv = 0; n_dstep = 0; n_dinv = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [6:0] seg;
    int         hold;
    int         digit;
    int         valid;
    int         steps;
    int         skips;
    int         invs;
    int         count;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int r, idx, n;
    vecs[0]  = '{7'h06, 6, 1,  1, 1, 0, 0, 1};
    vecs[1]  = '{7'h5B, 2, 1,  1, 0, 0, 0, 1};
    vecs[2]  = '{7'h06, 6, 1,  1, 0, 0, 0, 1};
    vecs[3]  = '{7'h5B, 6, 2,  1, 1, 0, 0, 2};
    vecs[4]  = '{7'h4F, 6, 3,  1, 1, 0, 0, 3};
    vecs[5]  = '{7'h6D, 6, 5,  1, 0, 1, 0, 3};
    vecs[6]  = '{7'h00, 6, 5,  0, 0, 0, 1, 3};
    vecs[7]  = '{7'h00, 6, 5,  0, 0, 0, 0, 3};
    vecs[8]  = '{7'h7D, 6, 6,  1, 0, 0, 0, 3};
    vecs[9]  = '{7'h07, 6, 7,  1, 1, 0, 0, 4};
    vecs[10] = '{7'h71, 6, 15, 1, 0, 1, 0, 4};
    vecs[11] = '{7'h3F, 6, 0,  1, 1, 0, 0, 5};

    clr();
    rst = 1'b1; ena = 1'b1; seg_in = 7'h00;
    tick();
    tick();
    check("reset_hex", {16'd0, digit_h, valid_h, step_h, skip_h, inv_h, count_h}, 32'd0);
    check("reset_dec", {16'd0, digit_d, valid_d, step_d, skip_d, inv_d, count_d}, 32'd0);
    rst = 1'b0;

    // First digit: committed exactly STABLE_CYCLES edges after first sample.
    clr();
    hold(7'h3F, SC);
    check("first_early", {31'd0, valid_h}, 32'd0);
    tick();
    check("first_commit", {16'd0, digit_h, valid_h, step_h, skip_h, inv_h, count_h},
          {16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    tick();

    for (int i = 0; i < 12; i++) begin
      clr();
      hold(vecs[i].seg, vecs[i].hold);
      check($sformatf("row%0d", i),
            {7'd0, digit_h, valid_h, 4'(n_step), 4'(n_skip), 4'(n_inv), count_h},
            {7'd0, 4'(vecs[i].digit), 1'(vecs[i].valid), 4'(vecs[i].steps),
             4'(vecs[i].skips), 4'(vecs[i].invs), 8'(vecs[i].count)});
    end

    // Decimal wrap 9->0 and A rejected in decimal mode.
    do_reset();
    for (int i = 0; i < 10; i++) hold(pats[i], 6);
    clr();
    hold(7'h3F, 6);
    check("dec_wrap", {16'd0, 4'(n_dstep), digit_d, 4'(n_skip), count_d}, {16'd0, 4'd1, 4'd0, 4'd1, 8'd10});
    clr();
    hold(7'h77, 6);
    check("dec_invalid_a", {24'd0, 4'(n_dinv), 3'd0, valid_d}, {24'd0, 4'd1, 3'd0, 1'b0});
    check("hex_a_skip", {24'd0, 4'(n_skip), digit_h}, {24'd0, 4'd1, 4'hA});

    // ena low mid-window freezes everything; counting resumes afterwards.
    do_reset();
    hold(7'h3F, 6);
    hold(7'h06, 2);
    clr();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seg_in = 7'($urandom);
      tick();
      check("ena_frozen", {16'd0, digit_h, valid_h, step_h, skip_h, inv_h, count_h},
            {16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    end
    ena = 1'b1;
    hold(7'h06, 2);
    check("ena_resume_wait", {28'd0, digit_h}, 32'd0);
    tick();
    check("ena_resume_commit", {16'd0, digit_h, 4'(n_step), count_h}, {16'd0, 4'd1, 4'd1, 8'd1});

    // Reset mid-window, then a fresh full window is required.
    hold(7'h5B, 2);
    do_reset();
    check("mid_reset", {16'd0, digit_h, valid_h, step_h, skip_h, inv_h, count_h}, 32'd0);
    clr();
    hold(7'h5B, SC);
    check("post_reset_wait", {31'd0, valid_h}, 32'd0);
    tick();
    check("post_reset_commit", {16'd0, digit_h, valid_h, 4'(n_step), 4'(n_skip), count_h},
          {16'd0, 4'd2, 1'b1, 4'd0, 4'd0, 8'd0});

    // 256 steps wrap step_count back to zero.
    do_reset();
    hold(7'h3F, 6);
    clr();
    for (int i = 1; i <= 256; i++) begin
      hold(pats[i % 16], SC + 1);
      if (i == 255) check("count_255", {24'd0, count_h}, 32'd255);
    end
    check("count_wrap", {16'd0, 8'(n_step), count_h}, {16'd0, 8'd0, 8'd0});
    check("count_wrap_steps", 32'(n_step), 32'd256);

    // Randomized run against the reference model.
    idx = 0;
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      if (r < 3) do_reset();
      if (r < 50) begin
        idx = (idx + 1) % 16;
        seg_in = pats[idx];
      end else if (r < 85) begin
        idx = $urandom_range(0, 15);
        seg_in = pats[idx];
      end else begin
        seg_in = 7'($urandom);
      end
      n = $urandom_range(1, 8);
      for (int c = 0; c < n; c++) begin
        ena = ($urandom_range(0, 9) != 0);
        tick();
      end
      ena = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_monitor.md
SEG7_MONITOR -- requirements
Module: seg7_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, cycles a segment pattern must hold before it is accepted; legal range 2-15.
REQ-002 SHALL have parameter HEX_MODE, default 1: 1 = digits 0-F, modulus 16; 0 = digits 0-9, modulus 10, with A-F patterns treated as invalid.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ena, input, 1, enable; low freezes all state.
REQ-006 SHALL have port seg_in, input, 7, segment bus, active-high; bit0=a through bit6=g.
REQ-007 SHALL have port digit, output, 4, last accepted digit value.
REQ-008 SHALL have port digit_valid, output, 1, high while digit reflects a valid accepted pattern.
REQ-009 SHALL have port step, output, 1, one-cycle pulse on a correct +1 (mod modulus) transition.
REQ-010 SHALL have port err_skip, output, 1, one-cycle pulse on a valid but non-sequential transition.
REQ-011 SHALL have port err_invalid, output, 1, one-cycle pulse on acceptance of an undecodable pattern.
REQ-012 SHALL have port step_count, output, 8, running count of step pulses.

Function
REQ-013 SHALL decode accepted patterns as follows: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (hex). Every other pattern is invalid, including blank 00.
REQ-014 SHALL hold a candidate register and a saturating stability counter.
- seg_in differs from candidate: load candidate, clear counter, clear committed flag.
- Otherwise: increment the counter, saturating at STABLE_CYCLES-1.
REQ-015 SHALL commit exactly once per stable run: on the edge where counter==STABLE_CYCLES-1, seg_in==candidate and committed flag is clear.
- Set the committed flag.
- Do nothing further if the candidate equals the last accepted pattern.
REQ-016 SHALL meet this latency: a pattern first sampled at edge k and held produces commit outputs registered at edge k+STABLE_CYCLES.
REQ-017 SHALL take the following actions on a commit of a valid pattern V:
- digit<=V; digit_valid<=1.
- If digit_valid was already 1 and V==(digit+1) mod modulus: step pulse, and step_count increments.
- If digit_valid was already 1 and V is not the next value: err_skip pulse.
- If digit_valid was 0 (first valid digit, or recovery after invalid): no step or err_skip pulse.
REQ-018 SHALL, on a commit of an invalid pattern: pulse err_invalid, clear digit_valid, hold digit.
- The last accepted pattern is updated, so a repeated invalid pattern does not re-pulse.
REQ-019 SHALL wrap step_count 255 -> 0 silently.
REQ-020 SHALL register all outputs; step, err_skip and err_invalid are mutually exclusive and high for one cycle only.
REQ-021 SHALL, while ena=0: hold all registers, force pulse outputs low, and ignore seg_in.
- On ena returning high, counting resumes from the held state.
REQ-022 SHALL treat a pattern change during the stability window as a restart; no commit occurs for a pattern that held fewer than STABLE_CYCLES consecutive samples.
REQ-023 SHALL wrap modulo 16 (HEX_MODE=1) or modulo 10 (HEX_MODE=0): F->0 or 9->0 is a step.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, clear the following regardless of ena, including mid-window:
- digit=0, digit_valid=0, step=0, err_skip=0, err_invalid=0, step_count=0.
- Candidate=00, counter=0, committed flag set, last accepted pattern=00.
REQ-025 SHALL require a fresh full stability window after reset release; a pattern already present needs STABLE_CYCLES samples before its first commit.

Verification
REQ-026 SHALL cover first digit: reset, seg_in=3F held, STABLE_CYCLES=4 -> at edge k+4, digit=0 and digit_valid=1, no pulses, step_count=0.
REQ-027 SHALL cover counting sequence: 3F, 06, 5B each held 6 cycles -> two step pulses, step_count=2, digit=2.
REQ-028 SHALL cover glitch rejection: digit=1 locked; seg_in=5B for 2 cycles, then back to 06 -> no pulse, digit stays 1.
REQ-029 SHALL cover skip and invalid: digit=3 locked, seg_in=6D held -> err_skip, digit=5; then seg_in=00 held -> err_invalid, digit_valid=0, digit=5.
REQ-030 SHALL cover wrap: HEX_MODE=0, digit=9, seg_in=3F -> step pulse. With HEX_MODE=0, seg_in=77 -> err_invalid. Drive 256 steps -> step_count=0.
REQ-031 SHALL cover ena and reset: ena=0 mid-window with seg_in changing -> outputs frozen. rst=1 mid-window -> all outputs zero next edge, and a subsequent commit needs a full window.
